// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The optional return stack is controlled by INSTRUCTION_FETCH_CALL_STACK_EN.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } if_state_e;

    localparam int INS_W           = 22;
    localparam int DEFAULT_ADDR_W  = 10;
    localparam int MAX_FLUSH_DEPTH = 3;

endpackage

// File: rtl/instruction_fetch_return_stack.sv
// Circular hardware return-address stack with sticky overflow/underflow flag.
// Only instantiated when INSTRUCTION_FETCH_CALL_STACK_EN is defined.
module return_stack
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] push_data_i,
    output logic [ADDR_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              err_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wp_q;
    logic [PTR_W:0]    cnt_q;
    logic              err_q;

    assign full_o     = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    // The newest entry sits just below the write pointer; empty pops read as 0.
    assign pop_data_o = empty_o ? '0 : mem_q[wp_q - PTR_W'(1)];
    assign err_o      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (pop_i) begin
            if (empty_o) begin
                err_q <= 1'b1;
            end else begin
                wp_q  <= wp_q - PTR_W'(1);
                cnt_q <= cnt_q - (PTR_W+1)'(1);
            end
        end else if (push_i) begin
            mem_q[wp_q] <= push_data_i;
            wp_q        <= wp_q + PTR_W'(1);
            // A push when full overwrites the oldest entry; depth stays saturated.
            if (full_o) err_q <= 1'b1;
            else        cnt_q <= cnt_q + (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Program counter and fetch control: ROM address, IR load strobe and bubble flag.
// Define INSTRUCTION_FETCH_CALL_STACK_EN to add the hardware return-address stack.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int FLUSH_DEPTH = 1,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              halt,
    input  logic              resume,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              ir_load,
    output logic              is_void,
    output logic              stack_err
);

    localparam int               CNT_W      = $clog2(MAX_FLUSH_DEPTH + 1);
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_DEPTH);

    if_state_e         state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ir_load_q;
    logic              is_void_q;

    logic              run_ok;
    logic              take_xfer;
    logic [ADDR_W-1:0] xfer_target;

    assign run_ok = (state_q == ST_RUN) && !halt && !stall;

`ifdef INSTRUCTION_FETCH_CALL_STACK_EN
    logic              take_ret;
    logic              take_call;
    logic [ADDR_W-1:0] ret_addr;
    logic              unused_stk_full;
    logic              unused_stk_empty;

    assign take_ret    = run_ok && ret;
    assign take_call   = run_ok && !ret && call;
    assign take_xfer   = run_ok && (ret || call || branch_taken);
    assign xfer_target = take_ret ? ret_addr : branch_target;

    // The current pc already points past the call, so it is the return address.
    return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_return_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (take_call),
        .pop_i       (take_ret),
        .push_data_i (pc_q),
        .pop_data_o  (ret_addr),
        .full_o      (unused_stk_full),
        .empty_o     (unused_stk_empty),
        .err_o       (stack_err)
    );
`else
    localparam int unused_stack_depth = STACK_DEPTH;
    logic          unused_ret;

    assign unused_ret  = ret;
    assign take_xfer   = run_ok && (call || branch_taken);
    assign xfer_target = branch_target;
    assign stack_err   = 1'b0;
`endif

    assign rom_addr = pc_q;
    assign ir_load  = ir_load_q;
    assign is_void  = is_void_q;

    // state | meaning
    // BOOT  | single post-reset cycle, IR contents invalid
    // RUN   | sequential fetch, control transfers accepted
    // FLUSH | voiding instructions fetched behind a transfer or resume
    // HALT  | pc frozen, IR void, waiting for resume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= '0;
            cnt_q     <= '0;
            ir_load_q <= 1'b0;
            is_void_q <= 1'b1;
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    state_q   <= ST_RUN;
                    pc_q      <= pc_q + ADDR_W'(1);
                    ir_load_q <= 1'b1;
                    is_void_q <= 1'b0;
                end
                ST_RUN, ST_FLUSH: begin
                    if (halt) begin
                        state_q   <= ST_HALT;
                        ir_load_q <= 1'b0;
                        is_void_q <= 1'b1;
                    end else if (stall) begin
                        ir_load_q <= 1'b0;
                    end else if (take_xfer) begin
                        state_q   <= ST_FLUSH;
                        pc_q      <= xfer_target;
                        cnt_q     <= FLUSH_INIT;
                        ir_load_q <= 1'b1;
                        is_void_q <= 1'b1;
                    end else if (state_q == ST_FLUSH) begin
                        pc_q      <= pc_q + ADDR_W'(1);
                        ir_load_q <= 1'b1;
                        if (cnt_q <= CNT_W'(1)) begin
                            cnt_q     <= '0;
                            state_q   <= ST_RUN;
                            is_void_q <= 1'b0;
                        end else begin
                            cnt_q     <= cnt_q - CNT_W'(1);
                            is_void_q <= 1'b1;
                        end
                    end else begin
                        pc_q      <= pc_q + ADDR_W'(1);
                        ir_load_q <= 1'b1;
                        is_void_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    // Resuming refetches at the held pc, but the stale IR is voided first.
                    if (!halt && resume) begin
                        state_q   <= ST_FLUSH;
                        cnt_q     <= FLUSH_INIT;
                        ir_load_q <= 1'b1;
                        is_void_q <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Program-counter and fetch-control stage sitting directly upstream of the instruction register. Drives the program ROM address and produces the per-cycle load strobe and `is_void` bubble flag that the instruction register consumes, so that instructions fetched behind a taken branch, call or return are squashed into clear-carry no-ops. Handles stall, halt/resume, and, optionally, a hardware return-address stack.

## Interface
Parameters:
- `ADDR_W`, 10: program-counter and ROM address width.
- `FLUSH_DEPTH`, 1: number of voided cycles after a taken control transfer (1..3).
- `STACK_DEPTH`, 4: return-stack entries. Power of two. Used only with the stack feature.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  freezes the PC, flush counter and outputs.
- `halt`  in  1  pulse that enters HALT.
- `resume`  in  1  pulse that leaves HALT.
- `branch_taken`  in  1  control transfer to `branch_target`.
- `branch_target`  in  ADDR_W  destination address.
- `call`  in  1  subroutine call to `branch_target`.
- `ret`  in  1  return to the popped address.
- `rom_addr`  out  ADDR_W  equals the `pc` register.
- `ir_load`  out  1  instruction register captures ROM data on this edge.
- `is_void`  out  1  to the instruction register. 1 forces a clear-carry no-op.
- `stack_err`  out  1  sticky stack overflow/underflow flag.

## Operation
- Reset values: `pc`=0, state BOOT, `ir_load`=0, `is_void`=1, `stack_err`=0, stack pointer 0, flush counter 0.
- The FSM has four states: BOOT, RUN, FLUSH and HALT.
- BOOT lasts one cycle, then goes to RUN. `ir_load` is 1 from the first RUN cycle.
- Priority order is `halt` > `stall` > `ret` > `call` > `branch_taken` > sequential increment.
- RUN with no event:
  - `pc` <= `pc`+1, wrapping modulo 2^ADDR_W (all ones goes to 0).
  - `ir_load`=1 and `is_void`=0.
- Taken transfer in RUN (`branch_taken`, `call` or `ret`):
  - `pc` <= target and the flush counter <= FLUSH_DEPTH.
  - State goes to FLUSH.
- FLUSH:
  - `ir_load`=1, `pc` increments, `is_void`=1 and the counter decrements.
  - When the counter reaches 0, return to RUN.
  - `branch_taken`, `call` and `ret` are ignored, because voided instructions cannot transfer control.
- `stall` (RUN or FLUSH):
  - `pc`, state and counter hold, and `ir_load`=0.
  - `is_void` holds its value.
  - A transfer presented during a stall is not taken; the requester holds it until the stall clears.
- `halt` from any state except BOOT:
  - Enter HALT with `ir_load`=0 and `is_void`=1. `pc` holds.
- HALT with `resume`:
  - Go to FLUSH with counter = FLUSH_DEPTH, so stale IR contents are voided.
  - `halt` and `resume` together in HALT: stay in HALT.
- Reset asserted mid-operation returns every register to its reset value immediately, including the stack and `stack_err`.

## Timing
- `rom_addr` is combinational from `pc`. The ROM is combinational.
- In RUN, the IR holds the instruction at address `pc`-1.
- Taken transfer sampled on edge N:
  - `rom_addr`=target after edge N.
  - `is_void`=1 for the FLUSH_DEPTH cycles after edge N.
  - The first non-void instruction is the one at the target, visible after edge N+FLUSH_DEPTH.
- `is_void` and `ir_load` are registered, so they are glitch-free.

## Configuration
- `INSTRUCTION_FETCH_CALL_STACK_EN` defined:
  - `call` pushes `pc` (the return address) and branches to `branch_target`.
  - `ret` pops the top entry and branches to it.
  - Push when full overwrites the oldest entry (circular) and sets `stack_err`.
  - Pop when empty yields address 0 and sets `stack_err`.
  - `call` and `ret` in the same cycle: `ret` wins and no push occurs.
- Macro undefined:
  - `call` behaves exactly like `branch_taken`, and `ret` is ignored.
  - `stack_err` is tied to 0, with no stack storage. Ports are unchanged.

## Structure
- Package `instruction_fetch_pkg` holds:
  - the FSM state enum (BOOT, RUN, FLUSH, HALT);
  - `INS_W`=22 and the default `ADDR_W`;
  - `MAX_FLUSH_DEPTH`=3.
- Sub-module `return_stack` (push/pop, full/empty, err) is instantiated only under the macro.

## Test plan
- Reset, then 5 free-running cycles:
  - `rom_addr` goes 0,1,2,3,4.
  - `is_void`=1 during BOOT, then 0.
  - `ir_load`=1 from RUN.
- `branch_taken` with target 0x2A0 at `pc`=7, FLUSH_DEPTH=1:
  - Next `rom_addr`=0x2A0, then 0x2A1.
  - `is_void`=1 for exactly 1 cycle.
  - A second `branch_taken` during FLUSH is ignored.
- `stall` held for 3 cycles at `pc`=0x10:
  - `rom_addr` stays 0x10 and `ir_load`=0 for 3 cycles.
  - Afterwards `pc` resumes at 0x11.
- `halt` at `pc`=0x20, `resume` 4 cycles later:
  - `is_void`=1 and `ir_load`=0 throughout HALT.
  - After resume, one voided fetch at 0x20, then 0x21 valid.
- With the macro, STACK_DEPTH=4:
  - Five calls set `stack_err`=1.
  - Four rets return the four newest return addresses.
  - A fifth ret goes to 0.
- `pc`=all ones with no event: next `rom_addr`=0.
